spi2dac: RTL and testbench



---
 rtl/spi2dac.sv | 185 ++++++++++++++++++
 tb/tb_spi2dac.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi2dac.sv
// spi2dac: serialises a 10-bit DAC code into a 16-bit MCP4911 SPI write frame (mode 0,0, MSB first).
// Latency: CS falls 1 cycle after load; a frame keeps busy high for 35*CLK_DIV cycles.
// Backpressure: a one-deep pending buffer absorbs a load during a frame; overwrite/discard pulses ovf.
// Optional LDAC strobe is enabled by defining SPI2DAC_LDAC_EN.
module spi2dac #(
    parameter int CLK_DIV = 25
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n,
    output logic       busy,
    output logic       ovf
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    hp_q, hp_d;        // half-period index inside SHIFT
    logic [15:0]   shift_q, shift_d;
    logic          cs_n_q, cs_n_d;
    logic          sck_q, sck_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          pend_q, pend_d;
    logic [9:0]    pdat_q, pdat_d;
    logic          tick;
    logic          start;
    logic [9:0]    start_dat;

    assign tick = (div_q == DIV_LAST);

    // Next-state logic: divider, frame sequencing, pending buffer and overflow detection.
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + 1'b1;
        hp_d      = hp_q;
        shift_d   = shift_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        busy_d    = busy_q;
        ovf_d     = 1'b0;
        pend_d    = pend_q;
        pdat_d    = pdat_q;
        start     = 1'b0;
        start_dat = data_in;

        // A load during a frame (but not on the GAP tick, where it starts a frame directly) is queued.
        if (load && (state_q != S_IDLE) && !((state_q == S_GAP) && tick)) begin
            pdat_d = data_in;
            pend_d = 1'b1;
            ovf_d  = pend_q;
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (load) begin
                    start = 1'b1;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_SHIFT;
                    hp_d    = '0;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    sck_d = ~sck_q;
                    hp_d  = hp_q + 1'b1;
                    // Odd half-period ends with a falling edge: advance data unless the last bit just went out.
                    if (hp_q[0]) begin
                        if (hp_q == 5'd31) begin
                            state_d = S_HOLD;
                        end else begin
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (load) begin
                        start  = 1'b1;
                        pend_d = 1'b0;
                        ovf_d  = pend_q;
                    end else if (pend_q) begin
                        start     = 1'b1;
                        start_dat = pdat_q;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
            end
        endcase

        if (start) begin
            shift_d = {4'b0111, start_dat, 2'b00};
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_SETUP;
            div_d   = '0;
            hp_d    = '0;
        end
    end

    // State registers with synchronous reset; reset mid-frame raises CS on the next edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            hp_q    <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            pdat_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hp_q    <= hp_d;
            shift_q <= shift_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            pdat_q  <= pdat_d;
        end
    end

`ifdef SPI2DAC_LDAC_EN
    logic ld_n_q;

    // LDAC is held low for the whole GAP half-period that follows every completed frame.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            ld_n_q <= 1'b1;
        end else if ((state_q == S_HOLD) && tick) begin
            ld_n_q <= 1'b0;
        end else if ((state_q == S_GAP) && tick) begin
            ld_n_q <= 1'b1;
        end
    end

    assign dac_ld_n = ld_n_q;
`else
    // Without LDAC the DAC updates on CS rising, so the latch pin is tied low.
    assign dac_ld_n = 1'b0;
`endif

    assign dac_cs_n = cs_n_q;
    assign dac_sck  = sck_q;
    assign dac_sdi  = shift_q[15];
    assign busy     = busy_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_spi2dac.sv
// Directed bench for spi2dac at CLK_DIV=2: frame contents, timing, queueing, overwrite, reset abort, LDAC.
// A negedge monitor decodes SPI frames, busy runs, CS gaps, ovf pulses and LDAC strobes into queues.
// Scenario tasks drive stimulus and compare monitor results against hand-computed values.
module tb_spi2dac;
    localparam int CLK_DIV = 2;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [9:0] data_in = '0;
    logic       load = 1'b0;
    logic       dac_cs_n, dac_sck, dac_sdi, dac_ld_n, busy, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    spi2dac #(.CLK_DIV(CLK_DIV)) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .data_in (data_in),
        .load    (load),
        .dac_cs_n(dac_cs_n),
        .dac_sck (dac_sck),
        .dac_sdi (dac_sdi),
        .dac_ld_n(dac_ld_n),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 sysclk = ~sysclk;

    // Monitor state
    logic [15:0] words[$];
    int          rises_q[$];
    int          busy_runs[$];
    int          gaps[$];
    int          ld_runs[$];
    logic [15:0] cur_word = '0;
    int          cur_rises = 0, cur_busy = 0, cur_gap = 0, cur_ld = 0;
    int          ovf_cnt = 0, ld_bad = 0, ld_misalign = 0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0, prev_ld = 1'b1;

    always @(negedge sysclk) begin
        if (!dac_cs_n && prev_cs) begin
            cur_word  = '0;
            cur_rises = 0;
        end
        if (dac_sck && !prev_sck && !dac_cs_n) begin
            cur_word  = {cur_word[14:0], dac_sdi};
            cur_rises = cur_rises + 1;
        end
        if (dac_cs_n && !prev_cs) begin
            words.push_back(cur_word);
            rises_q.push_back(cur_rises);
        end
        if (busy) cur_busy = cur_busy + 1;
        else if (prev_busy) begin
            busy_runs.push_back(cur_busy);
            cur_busy = 0;
        end
        if (busy && dac_cs_n) cur_gap = cur_gap + 1;
        if (!dac_cs_n && prev_cs && cur_gap > 0) begin
            gaps.push_back(cur_gap);
            cur_gap = 0;
        end
        if (!busy) cur_gap = 0;
        if (ovf) ovf_cnt = ovf_cnt + 1;
`ifdef SPI2DAC_LDAC_EN
        if (!dac_ld_n) cur_ld = cur_ld + 1;
        if (!dac_ld_n && prev_ld && !(dac_cs_n && !prev_cs)) ld_misalign = ld_misalign + 1;
        if (dac_ld_n && !prev_ld) begin
            ld_runs.push_back(cur_ld);
            cur_ld = 0;
        end
`else
        if (dac_ld_n !== 1'b0) ld_bad = ld_bad + 1;
`endif
        prev_cs   = dac_cs_n;
        prev_sck  = dac_sck;
        prev_busy = busy;
        prev_ld   = dac_ld_n;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            #1;
        end
    endtask

    task automatic clear_mon();
        words.delete();
        rises_q.delete();
        busy_runs.delete();
        gaps.delete();
        ovf_cnt = 0;
    endtask

    task automatic pulse_load(input logic [9:0] d);
        @(negedge sysclk);
        #1;
        data_in = d;
        load    = 1'b1;
        @(negedge sysclk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            step(1);
            if (!busy) break;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, i);
        end
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        n_checks++;
        if ({dac_cs_n, dac_sck, dac_sdi, busy, ovf} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_outputs: cs,sck,sdi,busy,ovf=%b required 10000",
                     {dac_cs_n, dac_sck, dac_sdi, busy, ovf});
        end
        n_checks++;
`ifdef SPI2DAC_LDAC_EN
        if (dac_ld_n !== 1'b1) begin
`else
        if (dac_ld_n !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL reset_ld_n: got %b", dac_ld_n);
        end
        reset = 1'b0;
        step(2);
        clear_mon();
    endtask

    task automatic test_single();
        clear_mon();
        pulse_load(10'h2AB);
        n_checks++;
        if ({dac_cs_n, busy, dac_sck, dac_sdi} !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_start: cs,busy,sck,sdi=%b required 0100", {dac_cs_n, busy, dac_sck, dac_sdi});
        end
        // First SCK rise is 2*CLK_DIV cycles after CS falls.
        step(2 * CLK_DIV - 1);
        n_checks++;
        if (dac_sck !== 1'b0) begin
            n_fail++;
            $display("FAIL single_sck_early: sck=%b required 0", dac_sck);
        end
        step(1);
        n_checks++;
        if (dac_sck !== 1'b1) begin
            n_fail++;
            $display("FAIL single_sck_first_rise: sck=%b required 1", dac_sck);
        end
        wait_idle();
        n_checks++;
        if (words.size() != 1 || words[0] !== 16'h7AAC || rises_q[0] != 16) begin
            n_fail++;
            $display("FAIL single_word: n=%0d word=%h rises=%0d required 1 7aac 16", words.size(),
                     (words.size() > 0) ? words[0] : 16'hxxxx, (rises_q.size() > 0) ? rises_q[0] : -1);
        end
        n_checks++;
        if (busy_runs.size() != 1 || busy_runs[0] != 35 * CLK_DIV) begin
            n_fail++;
            $display("FAIL single_busy_len: n=%0d len=%0d required 1 70", busy_runs.size(),
                     (busy_runs.size() > 0) ? busy_runs[0] : -1);
        end
    endtask

    task automatic test_full_zero();
        clear_mon();
        pulse_load(10'h3FF);
        wait_idle();
        n_checks++;
        if ({dac_cs_n, dac_sck} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_between: cs,sck=%b required 10", {dac_cs_n, dac_sck});
        end
        pulse_load(10'h000);
        wait_idle();
        n_checks++;
        if (words.size() != 2 || words[0] !== 16'h7FFC || words[1] !== 16'h7000) begin
            n_fail++;
            $display("FAIL full_zero_words: n=%0d w0=%h w1=%h required 2 7ffc 7000", words.size(),
                     (words.size() > 0) ? words[0] : 16'hxxxx, (words.size() > 1) ? words[1] : 16'hxxxx);
        end
    endtask

    task automatic test_queued();
        clear_mon();
        pulse_load(10'h100);
        step(20);
        pulse_load(10'h155);
        wait_idle();
        n_checks++;
        if (words.size() != 2 || words[0] !== 16'h7400 || words[1] !== 16'h7554) begin
            n_fail++;
            $display("FAIL queued_words: n=%0d w0=%h w1=%h required 2 7400 7554", words.size(),
                     (words.size() > 0) ? words[0] : 16'hxxxx, (words.size() > 1) ? words[1] : 16'hxxxx);
        end
        n_checks++;
        if (gaps.size() != 1 || gaps[0] != CLK_DIV) begin
            n_fail++;
            $display("FAIL queued_gap: n=%0d gap=%0d required 1 2", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
        end
        n_checks++;
        if (busy_runs.size() != 1 || busy_runs[0] != 70 * CLK_DIV) begin
            n_fail++;
            $display("FAIL queued_busy: n=%0d len=%0d required 1 140", busy_runs.size(),
                     (busy_runs.size() > 0) ? busy_runs[0] : -1);
        end
        n_checks++;
        if (ovf_cnt != 0) begin
            n_fail++;
            $display("FAIL queued_ovf: ovf cycles=%0d required 0", ovf_cnt);
        end
    endtask

    task automatic test_overwrite();
        clear_mon();
        pulse_load(10'h001);
        step(10);
        pulse_load(10'h002);
        step(10);
        pulse_load(10'h003);
        wait_idle();
        n_checks++;
        if (words.size() != 2 || words[0] !== 16'h7004 || words[1] !== 16'h700C) begin
            n_fail++;
            $display("FAIL overwrite_words: n=%0d w0=%h w1=%h required 2 7004 700c", words.size(),
                     (words.size() > 0) ? words[0] : 16'hxxxx, (words.size() > 1) ? words[1] : 16'hxxxx);
        end
        n_checks++;
        if (ovf_cnt != 1) begin
            n_fail++;
            $display("FAIL overwrite_ovf: ovf cycles=%0d required 1", ovf_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        clear_mon();
        pulse_load(10'h2AB);
        for (i = 0; i < 500; i++) begin
            if (cur_rises >= 5) break;
            step(1);
        end
        n_checks++;
        if (cur_rises < 5) begin
            n_fail++;
            $display("FAIL reset_mid_wait: rises=%0d required 5", cur_rises);
        end
        reset = 1'b1;
        step(1);
        n_checks++;
        if ({dac_cs_n, dac_sck, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_abort: cs,sck,busy=%b required 100", {dac_cs_n, dac_sck, busy});
        end
        reset = 1'b0;
        step(2);
        clear_mon();
        pulse_load(10'h2AB);
        wait_idle();
        n_checks++;
        if (words.size() != 1 || words[0] !== 16'h7AAC || rises_q[0] != 16) begin
            n_fail++;
            $display("FAIL reset_mid_clean: n=%0d word=%h rises=%0d required 1 7aac 16", words.size(),
                     (words.size() > 0) ? words[0] : 16'hxxxx, (rises_q.size() > 0) ? rises_q[0] : -1);
        end
    endtask

    task automatic test_ldac();
`ifdef SPI2DAC_LDAC_EN
        n_checks++;
        if (ld_runs.size() == 0 || ld_misalign != 0) begin
            n_fail++;
            $display("FAIL ldac_align: strobes=%0d misaligned=%0d required >0 and 0", ld_runs.size(), ld_misalign);
        end
        foreach (ld_runs[k]) begin
            n_checks++;
            if (ld_runs[k] != CLK_DIV) begin
                n_fail++;
                $display("FAIL ldac_len: strobe %0d low for %0d cycles required 2", k, ld_runs[k]);
            end
        end
`else
        n_checks++;
        if (ld_bad != 0) begin
            n_fail++;
            $display("FAIL ldac_tied: ld_n non-zero in %0d cycles required 0", ld_bad);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_zero();
        test_queued();
        test_overwrite();
        test_reset_mid();
        test_ldac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
